hash_byte_serializer: RTL and testbench
=======================================

Name: hash_byte_serializer

Overview:
- Transmit-side counterpart of the byte-serial command/data input path of the BLAKE2 core.
- When the compression engine finishes a message, it presents the final 512-bit chaining state h in a single-cycle pulse. This block latches h and the configured digest length nn.
- It then streams nn digest bytes out, one per cycle, least-significant byte first, with first/last markers. Its outputs drive the top-level hash_finished/hash byte pins.

Parameters:
- HASH_BYTES, 64, maximum digest length in bytes; state width is 8*HASH_BYTES.
- CNT_W, 7, byte-counter width; must satisfy 2^CNT_W > HASH_BYTES.

Ports:
- clk  in  1  clock.
- nreset  in  1  reset, synchronous, active-low.
- hash_v_i  in  1  single-cycle pulse: h_i and nn_i valid, final hash ready.
- h_i  in  8*HASH_BYTES  final chaining state; byte k = h_i[8k+7:8k].
- nn_i  in  8  requested digest length in bytes, sampled only with hash_v_i.
- hash_v_o  out  1  output byte valid.
- hash_o  out  8  digest byte.
- hash_first_o  out  1  high with the first byte of a digest.
- hash_last_o  out  1  high with the final byte of a digest (also the finished indication).
- busy_o  out  1  high while a digest is streaming.
- drop_o  out  1  one-cycle pulse when hash_v_i is rejected.

Behaviour:
- The state machine has two states, IDLE and STREAM. All outputs are registered.
- Reset (nreset=0 at a clk edge):
  - state = IDLE.
  - hash_v_o, hash_first_o, hash_last_o, busy_o, drop_o = 0.
  - hash_o = 8'h00, byte counter = 0.
  - The shift register content is don't-care.
  - Reset mid-stream aborts the stream immediately; no further bytes are emitted.
- Length rule: len = nn_i, with these exceptions:
  - nn_i > HASH_BYTES: len = HASH_BYTES (saturate).
  - nn_i == 0: the capture is rejected. drop_o pulses, state is unchanged, and no bytes are emitted.
- Accept condition: hash_v_i & (nn_i != 0) & (state==IDLE | (state==STREAM & current byte is the last)).
  - Back-to-back digests are therefore gapless: the first byte of the new digest follows the last byte of the old digest in the next cycle.
- On accept at edge N:
  - h_i is loaded into the shift register and len is stored.
  - The counter is set to 0 and state becomes STREAM.
- Latency: the first byte appears registered in cycle N+1, i.e. hash_v_o=1, hash_first_o=1, hash_o = h_i[7:0].
- STREAM, each cycle:
  - hash_v_o=1 and hash_o = byte cnt of the captured h.
  - The shift register shifts right by 8 and cnt increments.
  - hash_first_o=1 only when cnt==0.
  - hash_last_o=1 only when cnt==len-1. When len==1, first and last are both high in the same cycle.
  - After the last byte, state returns to IDLE (unless a back-to-back accept occurs). hash_v_o deasserts the following cycle.
- hash_o is forced to 8'h00 whenever hash_v_o=0.
- busy_o = (state==STREAM). It is high from cycle N+1 through the last-byte cycle inclusive.
- Rejection:
  - hash_v_i while in STREAM and not on the last byte: the request is ignored and drop_o pulses in the next cycle. The current stream continues unaffected.
  - The nn_i==0 case also pulses drop_o in the next cycle.
- Arithmetic: the counter is CNT_W bits and never wraps. Maximum value is HASH_BYTES-1. The len comparison is done at CNT_W width.
- There is no backpressure. The consumer must accept one byte per cycle.

Decomposition:
- Shared package blake2_io_pkg holds:
  - HASH_BYTES constant.
  - Enum serializer_state_t {IDLE, STREAM}.
  - Command constants CMD_CONF/START/DATA/LAST, shared with the input path.
- No sub-module is needed. The shift register, counter and FSM form a single module of about 150 lines.
- The top-level I/O wrapper instantiates this block, replacing the direct hash pass-through.

Test Plan:
- Full digest: h_i bytes = 0x00..0x3F, nn_i=64, one hash_v_i pulse -> 64 consecutive valid cycles starting N+1, hash_o = 0x00,0x01,...,0x3F. first on 0x00, last on 0x3F, busy_o high for exactly 64 cycles.
- Short and saturated lengths:
  - nn_i=1 -> one byte h_i[7:0], with first and last both high.
  - nn_i=32 -> bytes 0..31 only.
  - nn_i=200 -> 64 bytes (saturated).
  - nn_i=0 -> no output, drop_o pulse at N+1.
- Back-to-back: second hash_v_i (h=0xAA.., nn=4) coincides with the last byte of a nn=8 stream -> 8 bytes then immediately 4 bytes of 0xAA. The second stream's first is high the cycle after the first stream's last, with no idle gap.
- Collision: hash_v_i at cnt=3 of a nn=16 stream -> drop_o pulses once, all 16 original bytes unchanged, no second stream.
- Reset mid-stream: nreset=0 at cnt=10 of a nn=64 stream -> next cycle all outputs 0, hash_o=0x00. After release, a new hash_v_i with nn=2 streams 2 correct bytes.
- Idle check: 100 cycles without hash_v_i after reset -> hash_v_o, busy_o, drop_o all 0 and hash_o=0x00 throughout.

Source files
------------

// File: rtl/blake2_io_pkg.sv
// rtl/blake2_io_pkg.sv - shared constants and types for the BLAKE2 byte-serial I/O path
//
// Purpose: common definitions used by the command/data input path and the
// digest serializer.
// Contents:
//   HASH_BYTES          maximum digest length in bytes (state is 8*HASH_BYTES wide)
//   serializer_state_t  digest serializer FSM states
//   CMD_*               byte-serial command codes used by the input path
package blake2_io_pkg;

  localparam int HASH_BYTES = 64;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } serializer_state_t;

  localparam logic [7:0] CMD_CONF  = 8'h00;
  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_DATA  = 8'h02;
  localparam logic [7:0] CMD_LAST  = 8'h03;

endpackage

// File: rtl/hash_byte_serializer_if.sv
// rtl/hash_byte_serializer_if.sv - capture and byte-stream signals of the digest serializer
//
// Purpose: bundles the final-hash capture inputs and the digest byte outputs.
// Signals:
//   hash_v_i      final hash valid pulse (h_i, nn_i valid)
//   h_i           final chaining state, byte k = h_i[8k+7:8k]
//   nn_i          requested digest length in bytes
//   hash_v_o      digest byte valid
//   hash_o        digest byte
//   hash_first_o  first byte of a digest
//   hash_last_o   last byte of a digest
//   busy_o        digest streaming
//   drop_o        capture request rejected
// Modports: master drives the capture side, slave is the serializer.
interface hash_byte_serializer_if
  import blake2_io_pkg::*;
#(
  parameter int HASH_BYTES = blake2_io_pkg::HASH_BYTES
);

  logic                    hash_v_i;
  logic [8*HASH_BYTES-1:0] h_i;
  logic [7:0]              nn_i;
  logic                    hash_v_o;
  logic [7:0]              hash_o;
  logic                    hash_first_o;
  logic                    hash_last_o;
  logic                    busy_o;
  logic                    drop_o;

  modport master (
    output hash_v_i, h_i, nn_i,
    input  hash_v_o, hash_o, hash_first_o, hash_last_o, busy_o, drop_o
  );

  modport slave (
    input  hash_v_i, h_i, nn_i,
    output hash_v_o, hash_o, hash_first_o, hash_last_o, busy_o, drop_o
  );

endinterface

// File: rtl/hash_byte_serializer.sv
// rtl/hash_byte_serializer.sv - streams a captured final hash out one byte per cycle, LSB first
//
// Purpose: latches the final chaining state and digest length on a valid
// pulse, then emits len bytes with first/last markers. Back-to-back digests
// are accepted on the last byte of the running one so streams are gapless.
// Ports:
//   clk     clock
//   nreset  synchronous active-low reset
//   bus     hash_byte_serializer_if.slave (capture inputs, byte stream outputs)
module hash_byte_serializer
  import blake2_io_pkg::*;
#(
  parameter int HASH_BYTES = blake2_io_pkg::HASH_BYTES,
  parameter int CNT_W      = 7
) (
  input  logic                   clk,
  input  logic                   nreset,
  hash_byte_serializer_if.slave  bus
);

  serializer_state_t       r_state;
  serializer_state_t       w_state_nxt;
  logic [8*HASH_BYTES-1:0] r_shift;
  logic [8*HASH_BYTES-1:0] w_shift_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [CNT_W-1:0]        r_len;
  logic [CNT_W-1:0]        w_len_nxt;
  logic [CNT_W-1:0]        w_nn_len;

  logic                    w_at_last;
  logic                    w_accept;
  logic                    w_stream_nxt;

  logic                    r_hash_v;
  logic [7:0]              r_hash;
  logic                    r_first;
  logic                    r_last;
  logic                    r_drop;

  // Requested length saturated to the state size; compared at full width so
  // large nn_i values cannot alias.
  always_comb begin
    w_nn_len = CNT_W'(bus.nn_i);
    if (32'(bus.nn_i) > HASH_BYTES) begin
      w_nn_len = CNT_W'(HASH_BYTES);
    end
  end

  assign w_at_last = (r_state == STREAM) && (r_cnt == r_len - CNT_W'(1));
  // A new digest may start while idle or exactly on the last byte of the
  // running one; anything else is dropped.
  assign w_accept  = bus.hash_v_i && (bus.nn_i != 8'h00) &&
                     ((r_state == IDLE) || w_at_last);

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    if (w_accept) begin
      w_state_nxt = STREAM;
      w_shift_nxt = bus.h_i;
      w_cnt_nxt   = '0;
      w_len_nxt   = w_nn_len;
    end else if (r_state == STREAM) begin
      if (w_at_last) begin
        w_state_nxt = IDLE;
      end else begin
        w_shift_nxt = r_shift >> 8;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
    end
  end

  assign w_stream_nxt = (w_state_nxt == STREAM);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
    end
  end

  // Shift register content is irrelevant while idle, so it carries no reset.
  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
  end

  // Outputs are registered from next-state values so the byte presented in a
  // cycle always matches the state/counter held in that same cycle.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_hash_v <= 1'b0;
      r_hash   <= 8'h00;
      r_first  <= 1'b0;
      r_last   <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_hash_v <= w_stream_nxt;
      r_hash   <= w_stream_nxt ? w_shift_nxt[7:0] : 8'h00;
      r_first  <= w_stream_nxt && (w_cnt_nxt == '0);
      r_last   <= w_stream_nxt && (w_cnt_nxt == w_len_nxt - CNT_W'(1));
      r_drop   <= bus.hash_v_i && !w_accept;
    end
  end

  assign bus.hash_v_o     = r_hash_v;
  assign bus.hash_o       = r_hash;
  assign bus.hash_first_o = r_first;
  assign bus.hash_last_o  = r_last;
  assign bus.busy_o       = (r_state == STREAM);
  assign bus.drop_o       = r_drop;

endmodule

// File: tb/tb_hash_byte_serializer.sv
// tb/tb_hash_byte_serializer.sv - scoreboard bench for hash_byte_serializer
module tb_hash_byte_serializer;
  import blake2_io_pkg::*;

  typedef struct {
    logic [7:0] b;
    logic       f;
    logic       l;
    int         cyc;
  } exp_t;

  logic clk;
  logic nreset;
  int   cyc;
  int   total;
  int   bad;
  int   stream_end;
  bit   mon_en;
  exp_t exp_q[$];
  int   drop_q[$];

  hash_byte_serializer_if #(.HASH_BYTES(64)) bus ();

  hash_byte_serializer #(.HASH_BYTES(64), .CNT_W(7)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [511:0] pattern(input int base, input int step);
    logic [511:0] h;
    for (int k = 0; k < 64; k++) h[8*k +: 8] = 8'(base + k * step);
    return h;
  endfunction

  // Drive one capture pulse from the current cycle and record what must come back.
  task automatic issue(input logic [511:0] h, input int nn);
    int c;
    int len;
    c = cyc;
    bus.hash_v_i = 1'b1;
    bus.h_i      = h;
    bus.nn_i     = 8'(nn);
    if (nn != 0 && c >= stream_end) begin
      len = (nn > 64) ? 64 : nn;
      for (int k = 0; k < len; k++)
        exp_q.push_back('{h[8*k +: 8], (k == 0), (k == len - 1), c + 1 + k});
      stream_end = c + len;
    end else begin
      drop_q.push_back(c + 1);
    end
    @(posedge clk); #1;
    bus.hash_v_i = 1'b0;
    bus.nn_i     = 8'h00;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: compares every presented byte and drop pulse against the queues.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy_eq_valid", bus.busy_o, bus.hash_v_o);
      if (bus.hash_v_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", bus.hash_o, 32'hFFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("byte", bus.hash_o, e.b);
          chk("first", bus.hash_first_o, e.f);
          chk("last", bus.hash_last_o, e.l);
          chk("byte_cycle", cyc, e.cyc);
        end
      end else begin
        chk("idle_byte_zero", bus.hash_o, 0);
        chk("idle_markers", {bus.hash_first_o, bus.hash_last_o}, 0);
      end
      if (bus.drop_o) begin
        if (drop_q.size() == 0) chk("unexpected_drop", cyc, 32'hFFFF);
        else chk("drop_cycle", cyc, drop_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog expired: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int c0;
    total        = 0;
    bad          = 0;
    stream_end   = 0;
    mon_en       = 1'b0;
    nreset       = 1'b0;
    bus.hash_v_i = 1'b0;
    bus.h_i      = '0;
    bus.nn_i     = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hash_v", bus.hash_v_o, 0);
    chk("rst_hash", bus.hash_o, 0);
    chk("rst_first", bus.hash_first_o, 0);
    chk("rst_last", bus.hash_last_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_drop", bus.drop_o, 0);
    nreset = 1'b1;
    mon_en = 1'b1;

    // Idle: monitor flags any byte or drop with empty queues.
    wait_until(cyc + 100);

    // Full 64-byte digest 0x00..0x3F.
    issue(pattern(0, 1), 64);
    wait_until(cyc + 70);

    // Short, half, saturated and zero lengths.
    issue(pattern(8'h5A, 3), 1);
    wait_until(cyc + 4);
    issue(pattern(8'h80, 1), 32);
    wait_until(cyc + 36);
    issue(pattern(8'h11, 7), 200);
    wait_until(cyc + 70);
    issue(pattern(8'h33, 1), 0);
    wait_until(cyc + 4);

    // Back-to-back: second request on the last byte of an 8-byte stream.
    issue(pattern(8'h40, 1), 8);
    wait_until(stream_end);
    issue(pattern(8'hAA, 0), 4);
    wait_until(cyc + 8);

    // Collision at cnt=3 of a 16-byte stream.
    c0 = cyc;
    issue(pattern(8'hC0, 1), 16);
    wait_until(c0 + 4);
    issue(pattern(8'h01, 2), 8);
    wait_until(cyc + 20);

    // Reset while cnt=10 of a 64-byte stream.
    c0 = cyc;
    issue(pattern(8'h20, 5), 64);
    wait_until(c0 + 11);
    nreset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_hash_v", bus.hash_v_o, 0);
    chk("midrst_hash", bus.hash_o, 0);
    chk("midrst_busy", bus.busy_o, 0);
    chk("midrst_markers", {bus.hash_first_o, bus.hash_last_o}, 0);
    exp_q.delete();
    stream_end = 0;
    nreset = 1'b1;
    issue(pattern(8'h9C, 1), 2);
    wait_until(cyc + 6);

    chk("exp_q_drained", exp_q.size(), 0);
    chk("drop_q_drained", drop_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
